// File: rtl/coax_tx_pkg.sv
// Shared definitions for the 3270 coax transmitter and receiver: state encodings,
// frame field lengths and the word parity rule.
package coax_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_LINE_QUIESCE   = 3'd1,
    ST_CODE_VIOLATION = 3'd2,
    ST_SYNC           = 3'd3,
    ST_DATA           = 3'd4,
    ST_PARITY         = 3'd5,
    ST_END            = 3'd6
  } tx_state_e;

  localparam int LINE_QUIESCE_BITS   = 5;
  localparam int WORD_BITS           = 10;
  localparam int CODE_VIOLATION_BITS = 3;
  // END is one '0' cell, one high cell, and finishes half-way through a third cell
  localparam int END_BITS            = 3;

  typedef logic [3:0]           bit_idx_t;
  typedef logic [WORD_BITS-1:0] word_t;

  localparam bit_idx_t LQ_LAST_BIT   = bit_idx_t'(LINE_QUIESCE_BITS - 1);
  localparam bit_idx_t CV_LAST_BIT   = bit_idx_t'(CODE_VIOLATION_BITS - 1);
  localparam bit_idx_t DATA_LAST_BIT = bit_idx_t'(WORD_BITS - 1);
  localparam bit_idx_t END_LAST_BIT  = bit_idx_t'(END_BITS - 1);

  // Parity bit that gives the word plus parity an even number of ones
  function automatic logic coax_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Bit-cell timer: counts 0..CLOCKS_PER_BIT-1 and flags the half-bit and bit-end
// cycles; the FSM restarts it so each frame begins on a fresh cell.
module coax_tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic bit_start_o,
  output logic first_half_o,
  output logic half_bit_o,
  output logic end_of_bit_o
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(CLOCKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_start_o  = (cnt_q == '0);
  assign first_half_o = (cnt_q < CNT_HALF);
  assign half_bit_o   = (cnt_q == CNT_HALF_LAST);
  assign end_of_bit_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/coax_tx.sv
// IBM 3270 coax transmitter: one-word holding register feeding a bi-phase frame
// serialiser (quiesce, code violation, sync/data/parity per word, end sequence).
module coax_tx
  import coax_tx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 load,
  output logic                 ready,
  output logic                 tx,
  output logic                 active
);

  tx_state_e state_q, state_d;
  word_t     hold_q, hold_d;
  logic      hold_full_q, hold_full_d;
  word_t     shift_q, shift_d;
  logic      parity_q, parity_d;
  bit_idx_t  bit_idx_q, bit_idx_d;

  logic bit_start, first_half, half_bit, end_of_bit;
  logic timer_restart;
  logic sync_first;
  logic accept;

  assign sync_first = (state_q == ST_SYNC) && bit_start;
  assign accept     = load && ready;

  // Held at zero while idle so the first quiesce cell is full length
  assign timer_restart = (state_q == ST_IDLE) ||
                         ((state_q == ST_END) && (state_d == ST_IDLE));

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .restart_i   (timer_restart),
    .bit_start_o (bit_start),
    .first_half_o(first_half),
    .half_bit_o  (half_bit),
    .end_of_bit_o(end_of_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q || accept) begin
          state_d = ST_LINE_QUIESCE;
        end
      end
      ST_LINE_QUIESCE: begin
        if (end_of_bit && (bit_idx_q == LQ_LAST_BIT)) begin
          state_d = ST_CODE_VIOLATION;
        end
      end
      ST_CODE_VIOLATION: begin
        if (end_of_bit && (bit_idx_q == CV_LAST_BIT)) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (end_of_bit) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (end_of_bit && (bit_idx_q == DATA_LAST_BIT)) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        // A word arriving on this very cycle still chains into the frame
        if (end_of_bit) begin
          state_d = (hold_full_q || accept) ? ST_SYNC : ST_END;
        end
      end
      ST_END: begin
        if (half_bit && (bit_idx_q == END_LAST_BIT)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active = (state_q != ST_IDLE);
    ready  = !hold_full_q || sync_first;
    tx     = 1'b0;
    case (state_q)
      ST_LINE_QUIESCE,
      ST_SYNC:           tx = first_half;
      ST_CODE_VIOLATION: tx = (bit_idx_q == '0) ||
                              ((bit_idx_q == bit_idx_t'(1)) && first_half);
      ST_DATA:           tx = first_half ? shift_q[WORD_BITS-1] : !shift_q[WORD_BITS-1];
      ST_PARITY:         tx = first_half ? parity_q : !parity_q;
      ST_END:            tx = (bit_idx_q == '0) ? !first_half : 1'b1;
      default:           tx = 1'b0;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;

    if (sync_first) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      parity_d    = 1'b0;
    end
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end
    if ((state_q == ST_DATA) && end_of_bit) begin
      shift_d  = {shift_q[WORD_BITS-2:0], 1'b0};
      parity_d = parity_q ^ shift_q[WORD_BITS-1];
    end

    if (state_d != state_q) begin
      bit_idx_d = '0;
    end else if (end_of_bit) begin
      bit_idx_d = bit_idx_q + bit_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_coax_tx.sv
// Directed bench for coax_tx: compares the tx/active waveform cycle by cycle
// against a frame built from the line protocol, plus handshake spot checks.
module tb_coax_tx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       load;
  logic       ready;
  logic       tx;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;

  bit         exp_tx[$];
  bit         exp_act[$];
  bit         got_tx[$];
  bit         got_act[$];
  bit         got_rdy[$];
  int         sched_cyc[$];
  logic [9:0] sched_dat[$];
  int         rst_at;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .load  (load),
    .ready (ready),
    .tx    (tx),
    .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input bit lvl, input int n);
    repeat (n) begin
      exp_tx.push_back(lvl);
      exp_act.push_back(1'b1);
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) begin
      exp_tx.push_back(1'b0);
      exp_act.push_back(1'b0);
    end
  endtask

  task automatic push_bit(input bit b);
    push(b, HALF);
    push(!b, HALF);
  endtask

  task automatic push_frame_start();
    repeat (5) push_bit(1'b1);
    push(1'b1, 3 * HALF);
    push(1'b0, 3 * HALF);
  endtask

  task automatic push_word(input logic [9:0] w);
    int ones = 0;
    push_bit(1'b1);
    for (int i = 9; i >= 0; i--) begin
      push_bit(w[i]);
      if (w[i]) ones++;
    end
    push_bit((ones % 2) == 1);
  endtask

  task automatic push_frame_end();
    push_bit(1'b0);
    push(1'b1, 3 * HALF);
  endtask

  task automatic clear_test();
    exp_tx.delete();
    exp_act.delete();
    sched_cyc.delete();
    sched_dat.delete();
    rst_at = -1;
  endtask

  task automatic sched(input int c, input logic [9:0] d);
    sched_cyc.push_back(c);
    sched_dat.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycle k samples outputs at the falling edge, then drives that cycle's stimulus
  task automatic run(input int ncyc);
    got_tx.delete();
    got_act.delete();
    got_rdy.delete();
    while (exp_tx.size() < ncyc) push_idle(1);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      got_tx.push_back(tx);
      got_act.push_back(active);
      got_rdy.push_back(ready);
      load  = 1'b0;
      data  = 10'h000;
      reset = (k == rst_at);
      for (int i = 0; i < sched_cyc.size(); i++) begin
        if (sched_cyc[i] == k) begin
          load = 1'b1;
          data = sched_dat[i];
        end
      end
    end
    load  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic compare(input string tag);
    int mt = 0;
    int ma = 0;
    for (int k = 0; k < got_tx.size(); k++) begin
      if (got_tx[k] != exp_tx[k]) mt++;
      if (got_act[k] != exp_act[k]) ma++;
    end
    check({tag, "_tx_mismatches"}, mt, 0);
    check({tag, "_active_mismatches"}, ma, 0);
  endtask

  function automatic int act_count();
    int n = 0;
    foreach (got_act[k]) if (got_act[k]) n++;
    return n;
  endfunction

  function automatic int rdy_count();
    int n = 0;
    foreach (got_rdy[k]) if (got_rdy[k]) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    data  = 10'h000;
    rst_at = -1;

    // reset and idle
    repeat (5) @(negedge clk);
    reset = 1'b0;
    clear_test();
    run(100);
    check("rst_tx", got_tx[0], 0);
    check("rst_active", got_act[0], 0);
    check("rst_ready", got_rdy[0], 1);
    compare("idle");
    check("idle_ready_cycles", rdy_count(), 100);

    // single word
    do_reset();
    clear_test();
    sched(0, 10'h2A5);
    push_idle(1);
    push_frame_start();
    push_word(10'h2A5);
    push_frame_end();
    run(400);
    compare("single");
    check("single_len", act_count(), 360);
    check("single_first_tx", got_tx[1], 1);
    check("single_ready_after_load", got_rdy[1], 0);
    check("single_ready_sync", got_rdy[129], 1);
    check("single_parity_tx", got_tx[305], 1);
    check("single_tx_after", got_tx[361], 0);

    // chaining, second load on the first SYNC cycle
    do_reset();
    clear_test();
    sched(0, 10'h000);
    sched(129, 10'h3FF);
    push_idle(1);
    push_frame_start();
    push_word(10'h000);
    push_word(10'h3FF);
    push_frame_end();
    run(600);
    compare("chain");
    check("chain_len", act_count(), 552);
    check("chain_ready_sync1", got_rdy[129], 1);
    check("chain_ready_held", got_rdy[130], 0);
    check("chain_ready_sync2", got_rdy[321], 1);
    check("chain_ready_empty", got_rdy[322], 1);
    check("chain_parity0", got_tx[305], 0);
    check("chain_parity1", got_tx[497], 0);

    // overrun: middle word dropped
    do_reset();
    clear_test();
    sched(0, 10'h155);
    sched(5, 10'h0F0);
    sched(140, 10'h33C);
    push_idle(1);
    push_frame_start();
    push_word(10'h155);
    push_word(10'h33C);
    push_frame_end();
    run(600);
    compare("overrun");
    check("overrun_len", act_count(), 552);
    check("overrun_ready_busy", got_rdy[5], 0);
    check("overrun_ready_free", got_rdy[140], 1);

    // load on last PARITY cycle chains
    do_reset();
    clear_test();
    sched(0, 10'h2A5);
    sched(320, 10'h1C3);
    push_idle(1);
    push_frame_start();
    push_word(10'h2A5);
    push_word(10'h1C3);
    push_frame_end();
    run(600);
    compare("last_parity");
    check("last_parity_len", act_count(), 552);
    check("last_parity_ready", got_rdy[320], 1);

    // load on first END cycle starts a new frame after one idle cycle
    do_reset();
    clear_test();
    sched(0, 10'h2A5);
    sched(321, 10'h0F0);
    push_idle(1);
    push_frame_start();
    push_word(10'h2A5);
    push_frame_end();
    push_idle(1);
    push_frame_start();
    push_word(10'h0F0);
    push_frame_end();
    run(760);
    compare("end_load");
    check("end_load_len", act_count(), 720);
    check("end_load_gap", got_act[361], 0);
    check("end_load_restart", got_act[362], 1);
    check("end_load_ready_idle", got_rdy[361], 0);

    // reset during bit 4 of word 1 with a word buffered
    do_reset();
    clear_test();
    sched(0, 10'h2A5);
    sched(140, 10'h3C3);
    rst_at = 209;
    push_idle(1);
    push_frame_start();
    push_word(10'h2A5);
    push_word(10'h3C3);
    push_frame_end();
    while (exp_tx.size() > 210) begin
      void'(exp_tx.pop_back());
      void'(exp_act.pop_back());
    end
    run(500);
    compare("mid_reset");
    check("mid_reset_ready_before", got_rdy[209], 0);
    check("mid_reset_tx", got_tx[210], 0);
    check("mid_reset_active", got_act[210], 0);
    check("mid_reset_ready", got_rdy[210], 1);
    check("mid_reset_len", act_count(), 209);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
